// File: rtl/host_tx_axis_arbiter_pkg.sv
// host_tx_pkg: shared host TX stream constants, source ids, beat and FSM types
package host_tx_pkg;
  localparam int AXIS_DW = 512;
  localparam int SRC_ARP = 0;
  localparam int SRC_ROCE = 1;
  localparam int SRC_ACK = 2;
  typedef struct packed {
    logic [AXIS_DW-1:0] tdata;
    logic [AXIS_DW/8-1:0] tkeep;
    logic tlast;
  } axis_beat_t;
  typedef enum logic {IDLE, PASS} arb_state_t;
endpackage

// File: rtl/host_tx_axis_arbiter_if.sv
// host_tx_axis_arbiter_if: flattened multi-source AXIS inputs and merged AXIS output
interface host_tx_axis_arbiter_if
  import host_tx_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int DW = AXIS_DW
);
  logic [NUM_SRC*DW-1:0] s_axis_tdata;
  logic [NUM_SRC*DW/8-1:0] s_axis_tkeep;
  logic [NUM_SRC-1:0] s_axis_tvalid;
  logic [NUM_SRC-1:0] s_axis_tlast;
  logic [NUM_SRC-1:0] s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic m_axis_tvalid;
  logic m_axis_tlast;
  logic m_axis_tready;
  modport slave (
    input s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/host_tx_axis_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker searching upward from last_grant+1
module rr_pick #(
  parameter int NUM_SRC = 3,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] gnt_idx,
  output logic gnt_any
);
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (req[IW'((int'(last_grant) + k) % NUM_SRC)]) begin
        gnt_idx = IW'((int'(last_grant) + k) % NUM_SRC);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/host_tx_axis_arbiter.sv
// host_tx_axis_arbiter: packet-locked round-robin merge of host TX sources with accounting and stall watchdog
module host_tx_axis_arbiter
  import host_tx_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = AXIS_DW,
  parameter int NUM_SRC = 3,
  parameter int STALL_TIMEOUT = 1024,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic clk,
  input  logic rstn,
  host_tx_axis_arbiter_if.slave ax,
  output logic [IW-1:0] grant_id,
  output logic busy,
  output logic pkt_done,
  output logic [15:0] pkt_beats,
  output logic err_stall,
  input  logic err_clr
);
  localparam int KW = C_AXIS_DATA_WIDTH/8;
  arb_state_t state;
  logic [IW-1:0] last_grant, pick;
  logic pick_any, sel_v, hs, stall_hit;
  logic [15:0] beat_cnt, beat_inc, stall_cnt;
  logic [C_AXIS_DATA_WIDTH-1:0] src_data [NUM_SRC];
  logic [KW-1:0] src_keep [NUM_SRC];
  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req(ax.s_axis_tvalid),
    .last_grant(last_grant),
    .gnt_idx(pick),
    .gnt_any(pick_any)
  );
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_data[i] = ax.s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
    assign src_keep[i] = ax.s_axis_tkeep[i*KW +: KW];
    assign ax.s_axis_tready[i] = busy & (grant_id == IW'(i)) & ax.m_axis_tready;
  end
  assign busy = state == PASS;
  assign sel_v = ax.s_axis_tvalid[grant_id];
  assign ax.m_axis_tvalid = busy & sel_v;
  assign ax.m_axis_tlast = busy & ax.s_axis_tlast[grant_id];
  assign ax.m_axis_tdata = busy ? src_data[grant_id] : '0;
  assign ax.m_axis_tkeep = busy ? src_keep[grant_id] : '0;
  assign hs = ax.m_axis_tvalid & ax.m_axis_tready;
  assign beat_inc = beat_cnt == 16'hFFFF ? beat_cnt : beat_cnt + 16'd1;
  assign stall_hit = busy & ~sel_v & (stall_cnt == 16'(STALL_TIMEOUT - 1));
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      grant_id <= '0;
      last_grant <= IW'(NUM_SRC - 1);
      pkt_done <= 1'b0;
      pkt_beats <= '0;
      err_stall <= 1'b0;
      beat_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      pkt_done <= hs & ax.m_axis_tlast;
      err_stall <= stall_hit | (err_stall & ~err_clr);
      if (state == IDLE) begin
        stall_cnt <= '0;
        if (pick_any) begin
          grant_id <= pick;
          state <= PASS;
        end
      end else begin
        // counter parks at the timeout so err_stall fires once per stall episode
        stall_cnt <= sel_v ? '0 : stall_cnt == 16'(STALL_TIMEOUT) ? stall_cnt : stall_cnt + 16'd1;
        if (hs && ax.m_axis_tlast) begin
          last_grant <= grant_id;
          state <= IDLE;
          pkt_beats <= beat_inc;
          beat_cnt <= '0;
        end else if (hs) begin
          beat_cnt <= beat_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_host_tx_axis_arbiter.sv
// tb_host_tx_axis_arbiter: scoreboard bench for the host TX round-robin arbiter
module tb_host_tx_axis_arbiter;
  import host_tx_pkg::*;
  localparam int N = 3;
  localparam int DW = AXIS_DW;
  localparam int KW = DW/8;
  typedef struct {int src; axis_beat_t b;} sb_t;
  typedef struct {int src; int len;} pkt_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic err_clr = 1'b0;
  logic [1:0] grant_id;
  logic busy, pkt_done, err_stall;
  logic [15:0] pkt_beats;
  int checks = 0;
  int errors = 0;
  sb_t sb[$];
  pkt_t exp_pkt[$];
  host_tx_axis_arbiter_if #(.NUM_SRC(N), .DW(DW)) bus ();
  host_tx_axis_arbiter #(.C_AXIS_DATA_WIDTH(DW), .NUM_SRC(N), .STALL_TIMEOUT(1024)) dut (
    .clk(clk),
    .rstn(rstn),
    .ax(bus),
    .grant_id(grant_id),
    .busy(busy),
    .pkt_done(pkt_done),
    .pkt_beats(pkt_beats),
    .err_stall(err_stall),
    .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_hs(int s);
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (bus.s_axis_tready[s]) return;
    end
    chk("hs_timeout", bus.s_axis_tready[s], 1);
  endtask
  task automatic send_pkt(int s, int n, int stall);
    axis_beat_t b;
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < DW/32; w++) b.tdata[w*32 +: 32] = $urandom;
      b.tkeep = (k == n - 1) ? ({$urandom, $urandom} | 64'h1) : '1;
      b.tlast = k == n - 1;
      sb.push_back('{s, b});
      bus.s_axis_tdata[s*DW +: DW] = b.tdata;
      bus.s_axis_tkeep[s*KW +: KW] = b.tkeep;
      bus.s_axis_tlast[s] = b.tlast;
      bus.s_axis_tvalid[s] = 1'b1;
      wait_hs(s);
      @(posedge clk);
      #1;
      if (k == 0 && stall > 0) begin
        bus.s_axis_tvalid[s] = 1'b0;
        repeat (stall - 1) @(posedge clk);
        #1;
        chk("stall_early", err_stall, 0);
        @(posedge clk);
        #1;
        chk("stall_set", err_stall, 1);
        chk("stall_lock", busy, 1);
      end
    end
    bus.s_axis_tvalid[s] = 1'b0;
    bus.s_axis_tlast[s] = 1'b0;
  endtask
  // output monitor: grant order, beat content, hold stability, accounting
  bit mon_en = 0, chk_gap = 0, in_pkt = 0, done_due = 0, held = 0;
  int cyc = 0, last_t = -1, beats = 0, idx;
  pkt_t p = '{-1, 0};
  sb_t e;
  logic [DW+KW:0] prev, cur;
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      chk("pkt_done", pkt_done, done_due);
      if (pkt_done) chk("pkt_beats", pkt_beats, p.len);
      done_due = 0;
      cur = {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast};
      if (bus.m_axis_tvalid && !in_pkt) begin
        in_pkt = 1;
        beats = 0;
        p = exp_pkt.size() > 0 ? exp_pkt.pop_front() : '{-1, 0};
        chk("grant_id", grant_id, p.src);
        if (chk_gap && last_t >= 0) chk("gap", cyc - last_t, 2);
      end
      if (bus.m_axis_tvalid) begin
        chk("tready_mux", bus.s_axis_tready, bus.m_axis_tready ? 3'(1 << p.src) : 3'b0);
        if (held) chk("hold", cur, prev);
        held = !bus.m_axis_tready;
        prev = cur;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].src == p.src) idx = i;
        if (idx < 0) chk("sb_missing", idx, p.src);
        else begin
          e = sb[idx];
          sb.delete(idx);
          chk("tdata", bus.m_axis_tdata, e.b.tdata);
          chk("tkeep", bus.m_axis_tkeep, e.b.tkeep);
          chk("tlast", bus.m_axis_tlast, e.b.tlast);
        end
        beats++;
        if (bus.m_axis_tlast) begin
          chk("len", beats, p.len);
          done_due = 1;
          in_pkt = 0;
          last_t = cyc;
        end
      end
    end
  end
  bit t3_done = 0;
  initial begin
    bus.s_axis_tdata = '0;
    bus.s_axis_tkeep = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast = '0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mvalid", bus.m_axis_tvalid, 0);
    chk("rst_mdata", bus.m_axis_tdata, 0);
    chk("rst_tready", bus.s_axis_tready, 0);
    chk("rst_beats", pkt_beats, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_err", err_stall, 0);
    rstn = 1'b1;
    mon_en = 1;
    @(posedge clk);
    #1;
    // single beat from ARP, one-cycle arbitration latency
    exp_pkt.push_back('{SRC_ARP, 1});
    fork
      send_pkt(SRC_ARP, 1, 0);
      begin
        @(negedge clk);
        chk("lat_idle", bus.m_axis_tvalid, 0);
        @(negedge clk);
        chk("lat_first", bus.m_axis_tvalid, 1);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    // RoCE 4-beat packet under toggling backpressure
    exp_pkt.push_back('{SRC_ROCE, 4});
    fork
      begin
        send_pkt(SRC_ROCE, 4, 0);
        t3_done = 1;
      end
      for (int t = 0; t < 100 && !t3_done; t++) begin
        @(posedge clk);
        #1;
        bus.m_axis_tready = ~bus.m_axis_tready;
      end
    join
    bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // ACK source stalls mid-packet past the watchdog limit
    exp_pkt.push_back('{SRC_ACK, 2});
    send_pkt(SRC_ACK, 2, 1024);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", err_stall, 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("err_clr", err_stall, 0);
    // all sources back-to-back: strict rotation with one idle cycle between packets
    last_t = -1;
    chk_gap = 1;
    repeat (2) for (int s = 0; s < N; s++) exp_pkt.push_back('{s, 2});
    fork
      repeat (2) send_pkt(0, 2, 0);
      repeat (2) send_pkt(1, 2, 0);
      repeat (2) send_pkt(2, 2, 0);
    join
    repeat (3) @(posedge clk);
    #1;
    // ARP requests while RoCE is mid-packet
    last_t = -1;
    exp_pkt.push_back('{SRC_ROCE, 4});
    exp_pkt.push_back('{SRC_ARP, 1});
    fork
      send_pkt(SRC_ROCE, 4, 0);
      begin
        repeat (2) @(posedge clk);
        #1;
        send_pkt(SRC_ARP, 1, 0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    // reset during beat 2 of a 3-beat RoCE packet
    mon_en = 0;
    bus.s_axis_tdata[DW +: DW] = {16{32'hA5A5_0001}};
    bus.s_axis_tkeep[KW +: KW] = '1;
    bus.s_axis_tvalid[1] = 1'b1;
    wait_hs(1);
    @(posedge clk);
    #1;
    bus.s_axis_tdata[DW +: DW] = {16{32'hA5A5_0002}};
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mvalid", bus.m_axis_tvalid, 0);
    chk("midrst_tready", bus.s_axis_tready, 0);
    bus.s_axis_tvalid = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    in_pkt = 0;
    held = 0;
    done_due = 0;
    last_t = -1;
    mon_en = 1;
    for (int s = 0; s < N; s++) exp_pkt.push_back('{s, 1});
    fork
      send_pkt(0, 1, 0);
      send_pkt(1, 1, 0);
      send_pkt(2, 1, 0);
    join
    repeat (5) @(posedge clk);
    #1;
    chk("sb_left", sb.size(), 0);
    chk("pkt_left", exp_pkt.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/host_tx_axis_arbiter.md
Name: host_tx_axis_arbiter

Overview:
- Packet-level round-robin arbiter merging NUM_SRC host-side AXI-Stream TX sources onto the single 512-bit host TX stream toward the CMAC/ERNIC model.
- Typical sources: ARP generator (src 0), RoCE CM/SEND generator (src 1), RC ACK generator (src 2).
- A grant locks to one source from its first beat until its tlast handshake, so packets are never interleaved.
- Also provides packet/beat accounting and a mid-packet stall watchdog.

Parameters:
- C_AXIS_DATA_WIDTH, 512, tdata width per source and on the output.
- NUM_SRC, 3, number of requesters; legal range 2..8.
- STALL_TIMEOUT, 1024, consecutive granted-but-tvalid-low cycles mid-packet before err_stall sets; 16-bit counter.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- s_axis_tdata  in  NUM_SRC*C_AXIS_DATA_WIDTH  flattened source data, src i at slice i
- s_axis_tkeep  in  NUM_SRC*C_AXIS_DATA_WIDTH/8  flattened source keep
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tlast  in  NUM_SRC  per-source last
- s_axis_tready  out  NUM_SRC  per-source ready
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  merged data
- m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  merged keep
- m_axis_tvalid  out  1  merged valid
- m_axis_tlast  out  1  merged last
- m_axis_tready  in  1  downstream ready
- grant_id  out  $clog2(NUM_SRC)  currently or last granted source
- busy  out  1  high while a packet is locked
- pkt_done  out  1  one-cycle pulse after each completed packet
- pkt_beats  out  16  beat count of the last completed packet, saturating at 16'hFFFF
- err_stall  out  1  sticky stall-timeout flag
- err_clr  in  1  synchronous clear of err_stall

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; grant_id = 0; last_grant = NUM_SRC-1, so src 0 has top priority on the first arbitration.
  - All s_axis_tready = 0; m_axis_tvalid = 0; m_axis_tlast = 0; m_axis_tdata/tkeep = 0.
  - busy = 0; pkt_done = 0; pkt_beats = 0; err_stall = 0; beat and stall counters = 0.
- FSM has two states, IDLE and PASS.
- IDLE:
  - m_axis_tvalid = 0 and all s_axis_tready = 0.
  - If any s_axis_tvalid[i] is high, choose the first requester found searching from last_grant+1 upward, wrapping modulo NUM_SRC.
  - Register the choice into grant_id and go to PASS. Arbitration latency is one cycle: the first beat appears on m_axis in the cycle after the request is seen.
- PASS:
  - m_axis_* is a combinational mux of slice grant_id.
  - s_axis_tready[grant_id] = m_axis_tready; all other tready bits are 0.
  - On m_axis_tvalid & m_axis_tready & m_axis_tlast:
    - last_grant <= grant_id; state <= IDLE.
    - pkt_done pulses in the next cycle.
    - pkt_beats <= beat counter + 1 (saturating); beat counter cleared.
  - Each beat handshake without tlast increments the beat counter, saturating at 16'hFFFF.
- Inter-packet gap is exactly one cycle (the IDLE arbitration cycle), including when the same source requests back-to-back.
- Fairness: with all sources continuously requesting, the grant sequence is 0,1,2,0,1,2…
- A request that drops before being granted is simply not considered; requests are level-sensitive.
- Stall watchdog:
  - In PASS, the stall counter increments each cycle the granted source's tvalid is 0 and clears on any granted tvalid=1.
  - When it reaches STALL_TIMEOUT, err_stall <= 1. The counter holds; the packet is not aborted and the lock is kept.
  - err_clr clears err_stall; if err_clr and a new timeout occur in the same cycle, set wins.
- Backpressure: m_axis_tready = 0 freezes everything. tdata/tkeep/tlast stay stable because they are driven directly from the held source.
- grant_id stays at its last value in IDLE until the next arbitration.
- busy = (state == PASS).
- A single-beat packet (tvalid & tlast on the first beat) gives pkt_beats = 1 and spends one cycle in PASS.
- Reset asserted mid-packet returns to IDLE immediately with all readies low. The partial packet is dropped on the output side and the sources must restart.

Decomposition:
- Package host_tx_pkg holds:
  - the AXIS width constant (512);
  - source index constants SRC_ARP = 0, SRC_ROCE = 1, SRC_ACK = 2;
  - a packed struct for one AXIS beat (tdata, tkeep, tlast).
- One sub-module, rr_pick: purely combinational rotate-priority picker with inputs req[NUM_SRC] and last_grant, outputs gnt_idx and gnt_any. It is reused by other arbiters in the design.

Test Plan:
- Single source: src 0 sends a 1-beat packet (tkeep = 64'hFFFF_FFFF_FFFF_FFFF) with m_tready = 1 -> m_tvalid high 1 cycle after the request; output tdata equals the source data; pkt_beats = 1; pkt_done pulses once; grant_id = 0.
- All three sources continuously send 2-beat packets -> output grant order 0,1,2,0,1,2; no interleaving; exactly one idle cycle between packets; each pkt_beats = 2.
- Src 1 sends a 4-beat packet while m_tready toggles 1,0,1,0 -> output holds stable while stalled; s_axis_tready[1] mirrors m_tready; other tready bits stay 0; pkt_beats = 4.
- Src 2 is granted, sends 1 beat, then drops tvalid for 1024 cycles with STALL_TIMEOUT = 1024 -> err_stall rises in cycle 1024 and stays set. Src 2 resumes and sends tlast; pkt_done pulses. Pulsing err_clr clears err_stall.
- Src 0 requests while src 1 is mid-packet -> src 0 is granted only after src 1's tlast handshake plus one idle cycle.
- Reset (rstn low) asserted during beat 2 of a 3-beat packet -> all tready, m_tvalid and busy go 0 immediately. After release, the first requester is chosen starting from src 0.
